// File: rtl/dino_motion_if.sv
// Bundles the frame-rate control inputs and pose outputs of dino_motion.
// master: the game/renderer side driving buttons and reading the pose.
// slave:  the dino_motion block itself.
interface dino_motion_if;
    logic        frame_tick;
    logic        jump_btn;
    logic        duck_btn;
    logic        collision;
    logic        restart;
    logic [11:0] dino_y;
    logic [1:0]  dino_state;
    logic        airborne;
    logic        game_over;

    modport master (
        output frame_tick, jump_btn, duck_btn, collision, restart,
        input  dino_y, dino_state, airborne, game_over
    );

    modport slave (
        input  frame_tick, jump_btn, duck_btn, collision, restart,
        output dino_y, dino_state, airborne, game_over
    );
endinterface

// File: rtl/dino_motion.sv
// Per-frame dinosaur physics and pose controller (pixel clock domain).
// Position/velocity advance only on frame_tick; collision and restart act
// on any cycle. Optional macro DINO_FAST_FALL_EN: holding duck_btn while
// airborne doubles gravity for that frame's velocity update.
module dino_motion #(
    parameter int unsigned GROUND_Y    = 200,
    parameter int unsigned MIN_Y       = 16,
    parameter int unsigned JUMP_V      = 12,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned MAX_FALL    = 15,
    parameter int unsigned ANIM_FRAMES = 6
) (
    input  logic           pixel_clk,
    input  logic           rst,
    dino_motion_if.slave   bus
);

    typedef enum logic [1:0] {
        StRunA = 2'd0,
        StRunB = 2'd1,
        StJump = 2'd2,
        StDead = 2'd3
    } state_e;

    localparam logic        [11:0] GROUND_Y12  = 12'(GROUND_Y);
    localparam logic        [11:0] TAKEOFF_Y   = 12'(GROUND_Y - JUMP_V);
    localparam logic signed [12:0] GROUND_S    = 13'(GROUND_Y);
    localparam logic signed [12:0] MIN_S       = 13'(MIN_Y);
    localparam logic        [11:0] MIN_Y12     = 12'(MIN_Y);
    localparam int                 TAKEOFF_INT = int'(GRAVITY) - int'(JUMP_V);
    localparam logic signed [7:0]  TAKEOFF_VEL = 8'(TAKEOFF_INT);
    localparam logic signed [8:0]  MAX_FALL_S  = 9'(MAX_FALL);
    localparam logic signed [7:0]  MAX_FALL_V  = 8'(MAX_FALL);
    localparam logic signed [8:0]  GRAV_NORM   = 9'(GRAVITY);
    localparam logic        [7:0]  ANIM_LAST   = 8'(ANIM_FRAMES - 1);

    state_e             state_q, state_d;
    logic [11:0]        y_q, y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [7:0]         anim_q, anim_d;
    logic               pending_q, pending_d;
    logic               airborne_q, game_over_q;
    logic               jump_q, restart_q;

    logic               jump_edge;
    logic               restart_edge;
    logic signed [8:0]  grav;
    logic signed [8:0]  vel_sum;
    logic signed [7:0]  vel_clamped;
    logic signed [12:0] next_y;

    assign jump_edge    = bus.jump_btn & ~jump_q;
    assign restart_edge = bus.restart & ~restart_q;

`ifdef DINO_FAST_FALL_EN
    localparam logic signed [8:0] GRAV_FAST = 9'(2 * GRAVITY);
    assign grav = bus.duck_btn ? GRAV_FAST : GRAV_NORM;
`else
    logic unused_duck;
    assign grav        = GRAV_NORM;
    assign unused_duck = bus.duck_btn;
`endif

    // Airborne kinematics: candidate position and gravity-limited velocity.
    assign next_y      = $signed({1'b0, y_q}) + $signed({{5{vel_q[7]}}, vel_q});
    assign vel_sum     = $signed({vel_q[7], vel_q}) + grav;
    assign vel_clamped = (vel_sum > MAX_FALL_S) ? MAX_FALL_V : vel_sum[7:0];

    // Next-state logic: death/restart act immediately, motion only on frame_tick.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        vel_d     = vel_q;
        anim_d    = anim_q;
        pending_d = pending_q;

        // Pending jump lives until the next tick, used or not.
        if (bus.frame_tick) begin
            pending_d = 1'b0;
        end else if (jump_edge) begin
            pending_d = 1'b1;
        end

        if (state_q == StDead) begin
            if (restart_edge) begin
                state_d   = StRunA;
                y_d       = GROUND_Y12;
                vel_d     = '0;
                anim_d    = '0;
                pending_d = 1'b0;
            end
        end else if (bus.collision) begin
            // Freeze y and velocity; this cycle's tick is discarded.
            state_d = StDead;
        end else if (bus.frame_tick) begin
            case (state_q)
                StRunA, StRunB: begin
                    // Same-cycle edge counts for this tick.
                    if (pending_q || jump_edge) begin
                        state_d = StJump;
                        y_d     = TAKEOFF_Y;
                        vel_d   = TAKEOFF_VEL;
                    end else if (anim_q == ANIM_LAST) begin
                        anim_d  = '0;
                        state_d = (state_q == StRunA) ? StRunB : StRunA;
                    end else begin
                        anim_d = anim_q + 8'd1;
                    end
                end
                StJump: begin
                    if (!vel_q[7] && (next_y >= GROUND_S)) begin
                        state_d = StRunA;
                        y_d     = GROUND_Y12;
                        vel_d   = '0;
                        anim_d  = '0;
                    end else begin
                        y_d   = (next_y < MIN_S) ? MIN_Y12 : next_y[11:0];
                        vel_d = vel_clamped;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, pose and edge-detect registers.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q     <= StRunA;
            y_q         <= GROUND_Y12;
            vel_q       <= '0;
            anim_q      <= '0;
            pending_q   <= 1'b0;
            airborne_q  <= 1'b0;
            game_over_q <= 1'b0;
            jump_q      <= 1'b0;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            vel_q       <= vel_d;
            anim_q      <= anim_d;
            pending_q   <= pending_d;
            airborne_q  <= (state_d == StJump);
            game_over_q <= (state_d == StDead);
            jump_q      <= bus.jump_btn;
            restart_q   <= bus.restart;
        end
    end

    assign bus.dino_y     = y_q;
    assign bus.dino_state = state_q;
    assign bus.airborne   = airborne_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_dino_motion.sv
// Directed bench for dino_motion: animation cadence, jump trajectory,
// pending-jump lifetime, fast-fall landing, death, restart and reset.
module tb_dino_motion;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dino_motion_if bus ();

    dino_motion dut (
        .pixel_clk (clk),
        .rst       (rst),
        .bus       (bus)
    );

`ifdef DINO_FAST_FALL_EN
    localparam int EXP_LAND = 21;
    localparam int EXP_Y21  = 200;
`else
    localparam int EXP_LAND = 25;
    localparam int EXP_Y21  = 158;
`endif

    // Hand-computed y after each tick of a plain jump (GRAVITY=1, JUMP_V=12).
    int jump_y [25] = '{188, 177, 167, 158, 150, 143, 137, 132, 128, 125,
                        123, 122, 122, 123, 125, 128, 132, 137, 143, 150,
                        158, 167, 177, 188, 200};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic press_jump();
        bus.jump_btn = 1'b1;
        step();
        bus.jump_btn = 1'b0;
        step();
    endtask

    task automatic check_pose(input string tag, input int y, input int st);
        check({tag, "_y"}, 32'(bus.dino_y), y);
        check({tag, "_state"}, 32'(bus.dino_state), st);
    endtask

    initial begin
        int land;

        bus.frame_tick = 1'b0;
        bus.jump_btn   = 1'b0;
        bus.duck_btn   = 1'b0;
        bus.collision  = 1'b0;
        bus.restart    = 1'b0;
        rst            = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        check_pose("reset", 200, 0);
        check("reset_airborne", 32'(bus.airborne), 0);
        check("reset_game_over", 32'(bus.game_over), 0);

        // Grounded running: legs toggle after tick 6 and tick 12.
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_pose($sformatf("run_t%0d", k), 200, (k >= 6 && k < 12) ? 1 : 0);
            step();
        end

        // Jump edge with no tick: nothing moves until the tick arrives.
        press_jump();
        repeat (1000) step();
        check_pose("hold", 200, 0);

        // Full jump; extra jump edges at tick 5 and before tick 25 are ignored.
        for (int k = 1; k <= 25; k++) begin
            if (k == 5) bus.jump_btn = 1'b1;
            tick();
            bus.jump_btn = 1'b0;
            check_pose($sformatf("jump_t%0d", k), jump_y[k-1], (k < 25) ? 2 : 0);
            check($sformatf("jump_t%0d_airborne", k), 32'(bus.airborne), (k < 25) ? 1 : 0);
            step();
            if (k == 24) press_jump();
        end

        // The pending edge from before tick 25 must not survive into tick 26.
        tick();
        check_pose("no_stale_jump", 200, 0);
        step();

        // Duck held from tick 12 onwards.
        press_jump();
        land = 0;
        for (int k = 1; k <= 40 && land == 0; k++) begin
            if (k == 12) bus.duck_btn = 1'b1;
            tick();
            if (k == 21) check("ff_t21_y", 32'(bus.dino_y), EXP_Y21);
            if (bus.airborne == 1'b0) land = k;
            step();
        end
        bus.duck_btn = 1'b0;
        check("ff_land_tick", land, EXP_LAND);
        check_pose("ff_landed", 200, 0);

        // Collision together with tick 14: y frozen at 122, not 123.
        press_jump();
        for (int k = 1; k <= 13; k++) begin
            tick();
            step();
        end
        check("apex_y", 32'(bus.dino_y), 122);
        bus.collision = 1'b1;
        tick();
        bus.collision = 1'b0;
        check_pose("dead", 122, 3);
        check("dead_game_over", 32'(bus.game_over), 1);
        check("dead_airborne", 32'(bus.airborne), 0);
        repeat (3) begin
            tick();
            step();
        end
        check_pose("dead_ticks", 122, 3);

        // Restart edge with collision still high: restart wins that cycle.
        bus.collision = 1'b1;
        bus.restart   = 1'b1;
        step();
        check_pose("restart", 200, 0);
        check("restart_game_over", 32'(bus.game_over), 0);
        bus.collision = 1'b0;
        step();
        bus.restart = 1'b0;
        step();
        check_pose("restart_after", 200, 0);

        // Restart while airborne has no effect.
        press_jump();
        repeat (3) tick();
        check("run_restart_pre_y", 32'(bus.dino_y), 167);
        bus.restart = 1'b1;
        step();
        step();
        bus.restart = 1'b0;
        step();
        check_pose("run_restart", 167, 2);
        tick();
        check("run_restart_t4_y", 32'(bus.dino_y), 158);

        // Synchronous reset mid-jump beats a same-cycle tick.
        rst            = 1'b1;
        bus.frame_tick = 1'b1;
        step();
        rst            = 1'b0;
        bus.frame_tick = 1'b0;
        check_pose("rst_mid", 200, 0);
        check("rst_mid_airborne", 32'(bus.airborne), 0);
        tick();
        check_pose("rst_after_tick", 200, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
